uart_rx_fifo_ctrl: RTL and testbench

Parametrised receive FIFO for the APB UART, sitting between the RX shift/deserialiser and the APB register file. It stores data plus per-character line-status error bits, flags overrun on push-while-full and reports a programmable fill trigger. It maintains a FIFO-contains-error summary and an optional character-timeout indication for the interrupt controller.

---
 rtl/uart_rx_fifo_ctrl.sv | 150 +++++++++++++++
 tb/tb_uart_rx_fifo_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo_ctrl.sv
// Receive FIFO for the APB UART: character + line-status storage, overrun, fill trigger,
// error summary and optional character timeout (enabled by defining UART_RX_FIFO_TIMEOUT_EN).
module uart_rx_fifo_ctrl #(
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned ERR_W         = 3,
  parameter int unsigned TRIG0         = 1,
  parameter int unsigned TRIG1         = 4,
  parameter int unsigned TRIG2         = 8,
  parameter int unsigned TRIG3         = 14,
  parameter int unsigned TIMEOUT_CHARS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          fifo_rx_i,
  input  logic [ERR_W-1:0]           fifo_rx_err_i,
  input  logic                       fifo_rx_push_i,
  input  logic                       fifo_rx_pop_i,
  input  logic                       fifo_rx_reset_i,
  input  logic [1:0]                 fifo_rx_trig_level_i,
  input  logic                       fifo_rx_char_tick_i,
  input  logic                       fifo_rx_ovr_clr_i,
  output logic [DATA_W-1:0]          fifo_rx_o,
  output logic [ERR_W-1:0]           fifo_rx_err_o,
  output logic [$clog2(DEPTH):0]     fifo_rx_count_o,
  output logic                       fifo_rx_empty_o,
  output logic                       fifo_rx_full_o,
  output logic                       fifo_rx_triggered_o,
  output logic                       fifo_rx_overrun_o,
  output logic                       fifo_rx_err_any_o,
  output logic                       fifo_rx_timeout_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = ERR_W + DATA_W;

  logic [ENT_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             overrun_q, overrun_d;

  logic [ENT_W-1:0] head_entry;
  logic [ERR_W-1:0] head_err;
  logic             empty, full;
  logic             pop_acc, push_acc;
  logic [CNT_W-1:0] thresh;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign head_entry = mem_q[rd_ptr_q];
  assign head_err   = head_entry[ENT_W-1:DATA_W];

  // A pop frees a slot in the same cycle, so a full FIFO still takes a simultaneous push.
  assign pop_acc  = fifo_rx_pop_i & ~empty;
  assign push_acc = fifo_rx_push_i & (~full | pop_acc);

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;
    overrun_d = overrun_q;
    if (fifo_rx_reset_i) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      err_cnt_d = '0;
      overrun_d = 1'b0;
    end else begin
      if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d   = count_q + CNT_W'(push_acc) - CNT_W'(pop_acc);
      err_cnt_d = err_cnt_q + CNT_W'(push_acc & (|fifo_rx_err_i))
                            - CNT_W'(pop_acc & (|head_err));
      if (fifo_rx_push_i & full & ~pop_acc) overrun_d = 1'b1;
      else if (fifo_rx_ovr_clr_i)           overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage is left uninitialised; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_acc & ~fifo_rx_reset_i) mem_q[wr_ptr_q] <= {fifo_rx_err_i, fifo_rx_i};
  end

  always_comb begin
    thresh = CNT_W'(TRIG0);
    case (fifo_rx_trig_level_i)
      2'd0:    thresh = CNT_W'(TRIG0);
      2'd1:    thresh = CNT_W'(TRIG1);
      2'd2:    thresh = CNT_W'(TRIG2);
      default: thresh = CNT_W'(TRIG3);
    endcase
  end

  assign fifo_rx_o           = head_entry[DATA_W-1:0];
  assign fifo_rx_err_o       = empty ? '0 : head_err;
  assign fifo_rx_count_o     = count_q;
  assign fifo_rx_empty_o     = empty;
  assign fifo_rx_full_o      = full;
  assign fifo_rx_triggered_o = (count_q >= thresh);
  assign fifo_rx_overrun_o   = overrun_q;
  assign fifo_rx_err_any_o   = (err_cnt_q != '0);

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CHARS + 1);

  logic [TO_W-1:0] idle_q, idle_d;

  // Any FIFO activity or an empty FIFO restarts the idle count; ticks saturate at the limit.
  always_comb begin
    idle_d = idle_q;
    if (fifo_rx_reset_i | push_acc | pop_acc | empty)
      idle_d = '0;
    else if (fifo_rx_char_tick_i && (idle_q != TO_W'(TIMEOUT_CHARS)))
      idle_d = idle_q + TO_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end

  assign fifo_rx_timeout_o = (idle_q == TO_W'(TIMEOUT_CHARS)) & ~empty;
`else
  logic unused_char_tick;
  assign unused_char_tick  = fifo_rx_char_tick_i;
  assign fifo_rx_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Self-checking bench for uart_rx_fifo_ctrl against a queue-based reference model.
module tb_uart_rx_fifo_ctrl;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ERR_W  = 3;
  localparam int TOC    = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  int trigTab [4] = '{1, 4, 8, 14};

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] rxData;
  logic [ERR_W-1:0]  rxErr;
  logic              push, pop, flush, tick, ovrClr;
  logic [1:0]        lvl;
  logic [DATA_W-1:0] headData;
  logic [ERR_W-1:0]  headErr;
  logic [CNT_W-1:0]  count;
  logic              empty, full, triggered, overrun, errAny, timeout;

  uart_rx_fifo_ctrl dut (
    .clk                  (clk),
    .reset                (reset),
    .fifo_rx_i            (rxData),
    .fifo_rx_err_i        (rxErr),
    .fifo_rx_push_i       (push),
    .fifo_rx_pop_i        (pop),
    .fifo_rx_reset_i      (flush),
    .fifo_rx_trig_level_i (lvl),
    .fifo_rx_char_tick_i  (tick),
    .fifo_rx_ovr_clr_i    (ovrClr),
    .fifo_rx_o            (headData),
    .fifo_rx_err_o        (headErr),
    .fifo_rx_count_o      (count),
    .fifo_rx_empty_o      (empty),
    .fifo_rx_full_o       (full),
    .fifo_rx_triggered_o  (triggered),
    .fifo_rx_overrun_o    (overrun),
    .fifo_rx_err_any_o    (errAny),
    .fifo_rx_timeout_o    (timeout)
  );

  always #5 clk = ~clk;

  // Reference model state: queue of {err, data}, sticky overrun, idle character count.
  logic [ERR_W+DATA_W-1:0] modelQ [$];
  bit modelOvr;
  int modelIdle;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit modelErrAny();
    foreach (modelQ[i]) if (modelQ[i][DATA_W +: ERR_W] != '0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelReset();
    modelQ.delete();
    modelOvr  = 1'b0;
    modelIdle = 0;
  endtask

  task automatic checkOutput(input string tag);
    int n;
    bit expTo;
    n = modelQ.size();
`ifdef UART_RX_FIFO_TIMEOUT_EN
    expTo = (modelIdle == TOC) && (n != 0);
`else
    expTo = 1'b0;
`endif
    chk({tag, ".count"},   32'(count),     32'(n));
    chk({tag, ".empty"},   32'(empty),     32'(n == 0));
    chk({tag, ".full"},    32'(full),      32'(n == DEPTH));
    chk({tag, ".trig"},    32'(triggered), 32'(n >= trigTab[lvl]));
    chk({tag, ".ovr"},     32'(overrun),   32'(modelOvr));
    chk({tag, ".errany"},  32'(errAny),    32'(modelErrAny()));
    chk({tag, ".timeout"}, 32'(timeout),   32'(expTo));
    if (n == 0) chk({tag, ".errhead"}, 32'(headErr), 32'(0));
    else begin
      chk({tag, ".errhead"}, 32'(headErr),  32'(modelQ[0][DATA_W +: ERR_W]));
      chk({tag, ".data"},    32'(headData), 32'(modelQ[0][DATA_W-1:0]));
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model, then compare.
  task automatic applyStimulus(input string tag, input bit doPush, input bit doPop,
                               input logic [7:0] d, input logic [2:0] e,
                               input bit doFlush = 0, input bit doTick = 0,
                               input bit doClr = 0);
    bit popA, pushA, wasFull, wasEmpty;
    @(negedge clk);
    push = doPush; pop = doPop; rxData = d; rxErr = e;
    flush = doFlush; tick = doTick; ovrClr = doClr;
    @(posedge clk);
    wasEmpty = (modelQ.size() == 0);
    wasFull  = (modelQ.size() == DEPTH);
    if (doFlush) modelReset();
    else begin
      popA  = doPop && !wasEmpty;
      pushA = doPush && (!wasFull || popA);
      if (doPush && wasFull && !popA) modelOvr = 1'b1;
      else if (doClr)                  modelOvr = 1'b0;
      if (popA)  void'(modelQ.pop_front());
      if (pushA) modelQ.push_back({e, d});
      if (pushA || popA || wasEmpty) modelIdle = 0;
      else if (doTick && modelIdle < TOC) modelIdle++;
    end
    #1;
    checkOutput(tag);
  endtask

  initial begin
    reset = 1'b1; push = 0; pop = 0; flush = 0; tick = 0; ovrClr = 0;
    rxData = '0; rxErr = '0; lvl = 2'd3;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset");
    @(negedge clk);
    reset = 1'b0;

    // Trigger level 3 (14 entries) and in-order drain.
    for (int i = 0; i < 14; i++) applyStimulus("fill14", 1, 0, 8'(8'h11 + i), 3'b000);
    chk("trig14.triggered", 32'(triggered), 32'(1));
    chk("trig14.count", 32'(count), 32'(14));
    chk("trig14.full", 32'(full), 32'(0));
    for (int i = 0; i < 14; i++) begin
      chk("drain.order", 32'(headData), 32'(8'h11 + i));
      applyStimulus("drain14", 0, 1, 8'h00, 3'b000);
    end
    chk("drain.empty", 32'(empty), 32'(1));

    // Overrun, clear, and full push+pop.
    for (int i = 0; i < 16; i++) applyStimulus("fill16", 1, 0, 8'($urandom_range(0, 255)), 3'b000);
    applyStimulus("overrun", 1, 0, 8'hAA, 3'b000);
    chk("overrun.set", 32'(overrun), 32'(1));
    applyStimulus("ovrclr", 0, 0, 8'h00, 3'b000, 0, 0, 1);
    chk("overrun.clr", 32'(overrun), 32'(0));
    applyStimulus("fullpp", 1, 1, 8'hBB, 3'b000);
    chk("fullpp.count", 32'(count), 32'(16));
    while (modelQ.size() > 1) applyStimulus("drainbb", 0, 1, 8'h00, 3'b000);
    chk("fullpp.last", 32'(headData), 32'(8'hBB));
    applyStimulus("drainbb", 0, 1, 8'h00, 3'b000);

    // Error summary.
    applyStimulus("err41", 1, 0, 8'h41, 3'b010);
    applyStimulus("err42", 1, 0, 8'h42, 3'b000);
    chk("err.any", 32'(errAny), 32'(1));
    chk("err.head", 32'(headErr), 32'(3'b010));
    applyStimulus("errpop", 0, 1, 8'h00, 3'b000);
    chk("err.cleared", 32'(errAny), 32'(0));
    chk("err.head42", 32'(headData), 32'(8'h42));
    applyStimulus("errpop", 0, 1, 8'h00, 3'b000);

    // Pointer wrap with small occupancy.
    lvl = 2'd1;
    for (int i = 0; i < 40; i++) begin
      bit pu, po;
      pu = (modelQ.size() < 3) && ($urandom_range(0, 1) == 1);
      po = (modelQ.size() > 0) && ($urandom_range(0, 1) == 1);
      if (modelQ.size() == 3) po = 1;
      applyStimulus("wrap", pu, po, 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
      chk("wrap.max3", 32'(count <= 3), 32'(1));
    end
    while (modelQ.size() > 0) applyStimulus("wrapdrain", 0, 1, 8'h00, 3'b000);

    // Character timeout.
    applyStimulus("to.push", 1, 0, 8'h5A, 3'b000);
    for (int i = 0; i < 4; i++) applyStimulus("to.tick", 0, 0, 8'h00, 3'b000, 0, 1);
`ifdef UART_RX_FIFO_TIMEOUT_EN
    chk("to.asserted", 32'(timeout), 32'(1));
`else
    chk("to.tiedoff", 32'(timeout), 32'(0));
`endif
    applyStimulus("to.pop", 0, 1, 8'h00, 3'b000);
    chk("to.cleared", 32'(timeout), 32'(0));

    // Flush overrides a simultaneous push.
    for (int i = 0; i < 5; i++) applyStimulus("preflush", 1, 0, 8'(8'h60 + i), 3'(i));
    applyStimulus("flush", 1, 0, 8'h77, 3'b001, 1);
    chk("flush.count", 32'(count), 32'(0));
    chk("flush.empty", 32'(empty), 32'(1));
    chk("flush.errany", 32'(errAny), 32'(0));

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      lvl = 2'($urandom_range(0, 3));
      applyStimulus("rand", $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45,
                    8'($urandom_range(0, 255)),
                    ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                    $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 40,
                    $urandom_range(0, 99) < 10);
    end

    // Asynchronous reset in the middle of a push cycle.
    for (int i = 0; i < 3; i++) applyStimulus("prereset", 1, 0, 8'(8'h90 + i), 3'b100);
    @(negedge clk);
    push = 1; rxData = 8'hEE; rxErr = 3'b111;
    #2 reset = 1'b1;
    modelReset();
    #1;
    checkOutput("asyncreset");
    push = 0;
    @(negedge clk);
    reset = 1'b0;
    applyStimulus("postreset", 1, 0, 8'hC3, 3'b000);
    applyStimulus("postreset", 0, 0, 8'h00, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
